uart_tx_serializer: RTL and testbench

//   8N1 UART transmitter directly downstream of the terminal buffer: takes

---
 rtl/uart_tx_serializer.sv | 128 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter with a one-entry holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2 frames).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 217,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_v,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overrun,
  output logic       o_tx
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic [7:0]    data;
  logic [7:0]    hold;
  logic          hold_v;
  logic          overrun;

  logic tick;
  logic last_stop;
  logic end_frame;
  logic launch;
  logic reload;

  assign tick      = (timer == TMAX);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign end_frame = (state == S_STOP) && tick && last_stop;
  // A strobe at the end of a frame with nothing held starts the next frame.
  assign launch    = i_byte_v && !hold_v
                   && ((state == S_IDLE) || end_frame);
  assign reload    = end_frame && hold_v;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_byte_v) state_nx = S_START;
      S_START: if (tick) state_nx = S_DATA;
      S_DATA:
        if (tick && bit_cnt == 3'd7)
`ifdef UART_TX_PARITY_EN
          state_nx = S_PARITY;
      S_PARITY:
        if (tick)
`endif
          state_nx = S_STOP;
      S_STOP:
        if (end_frame)
          state_nx = (hold_v || i_byte_v) ? S_START : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_tx = 1'b1;
    case (state)
      S_START:  o_tx = 1'b0;
      S_DATA:   o_tx = data[bit_cnt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: o_tx = ^data;
`endif
      default:  o_tx = 1'b1;
    endcase
    o_busy    = (state != S_IDLE);
    o_done    = end_frame;
    o_ready   = !hold_v;
    o_overrun = overrun;
  end

  // Bit timing, shift data, holding register and overrun pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      data     <= 8'h00;
      hold     <= 8'h00;
      hold_v   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == S_IDLE || tick) timer <= '0;
      else                         timer <= timer + TW'(1);
      if (state == S_DATA && tick) bit_cnt <= bit_cnt + 3'd1;
      if (state == S_STOP && tick) stop_cnt <= !last_stop;
      if (launch)      data <= i_byte;
      else if (reload) data <= hold;
      if (i_byte_v && !launch) begin
        if (hold_v) overrun <= 1'b1;
        else begin
          hold   <= i_byte;
          hold_v <= 1'b1;
        end
      end
      if (reload) hold_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of frame timing, queuing,
// overrun and mid-frame reset for uart_tx_serializer (CLKS_PER_BIT=4).
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB   = 10 + P + SB - 1;
  localparam int LAST = NB * CPB - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_v = 1'b0;
  logic       o_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_overrun;
  logic       o_tx;

  int tests  = 0;
  int failed = 0;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(SB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_byte(i_byte),
    .i_byte_v(i_byte_v),
    .o_ready(o_ready),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_overrun(o_overrun),
    .o_tx(o_tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Strobe a byte from IDLE; returns in the first START cycle.
  task automatic strobe(input logic [7:0] b);
    i_byte   = b;
    i_byte_v = 1'b1;
    tick();
    i_byte_v = 1'b0;
  endtask

  // Check one whole frame starting in its first START cycle.
  // sa/sb: iteration at which an extra byte is strobed (-1 none).
  // ovr: iteration with o_overrun expected; rlo: o_ready low from here.
  task automatic frame(input logic [7:0] b,
                       input int sa, input logic [7:0] ba,
                       input int sb, input logic [7:0] bb,
                       input int ovr, input int rlo);
    logic [NB-1:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[k];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    for (int i = 0; i <= LAST; i++) begin
      chk($sformatf("tx[%02h]@%0d", b, i), o_tx, bits[i/CPB]);
      chk($sformatf("done[%02h]@%0d", b, i), o_done, i == LAST);
      chk($sformatf("busy[%02h]@%0d", b, i), o_busy, 1'b1);
      chk($sformatf("ovr[%02h]@%0d", b, i), o_overrun, i == ovr);
      chk($sformatf("rdy[%02h]@%0d", b, i), o_ready,
          !(rlo >= 0 && i >= rlo));
      i_byte_v = 1'b0;
      if (i == sa) begin i_byte = ba; i_byte_v = 1'b1; end
      if (i == sb) begin i_byte = bb; i_byte_v = 1'b1; end
      tick();
    end
    i_byte_v = 1'b0;
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_tx", o_tx, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_done", o_done, 1'b0);
    chk("rst_ovr", o_overrun, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_tx", o_tx, 1'b1);

    // single byte 0x41 from IDLE
    strobe(8'h41);
    frame(8'h41, -1, 8'h00, -1, 8'h00, -1, -1);
    chk("t1_busy_end", o_busy, 1'b0);
    chk("t1_tx_end", o_tx, 1'b1);
    tick();

    // 0x55 then 0xA3 strobed 8 clocks later: contiguous frames
    strobe(8'h55);
    frame(8'h55, 7, 8'hA3, -1, 8'h00, -1, 8);
    frame(8'hA3, -1, 8'h00, -1, 8'h00, -1, -1);
    chk("t2_busy_end", o_busy, 1'b0);
    tick();

    // three strobes while busy: 0x33 dropped with overrun
    strobe(8'h11);
    frame(8'h11, 3, 8'h22, 5, 8'h33, 6, 4);
    frame(8'h22, -1, 8'h00, -1, 8'h00, -1, -1);
    chk("t3_busy_end", o_busy, 1'b0);
    tick();

    // strobe on the last stop cycle with hold empty: new launch
    strobe(8'h0F);
    frame(8'h0F, LAST, 8'hF0, -1, 8'h00, -1, -1);
    frame(8'hF0, -1, 8'h00, -1, 8'h00, -1, -1);
    chk("t7_busy_end", o_busy, 1'b0);
    tick();

    // reset at clk 15 of a 0x00 frame
    strobe(8'h00);
    for (int c = 1; c < 15; c++) tick();
    chk("t4_tx_pre", o_tx, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_tx_rst", o_tx, 1'b1);
    chk("t4_busy_rst", o_busy, 1'b0);
    chk("t4_ready_rst", o_ready, 1'b1);
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("t4_nodone@%0d", c), o_done, 1'b0);
      chk($sformatf("t4_idle@%0d", c), o_tx, 1'b1);
      tick();
    end
    strobe(8'h7E);
    frame(8'h7E, -1, 8'h00, -1, 8'h00, -1, -1);
    chk("t4_busy_end", o_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
